boreal_spectral_serializer: RTL and testbench
=============================================

BOREAL_SPECTRAL_SERIALIZER -- requirements
Module: boreal_spectral_serializer

Interface
REQ-001 SHALL provide the following ports, with clock and reset first:
  clk  in  1  sole clock; all state changes on its rising edge.
  rst  in  1  synchronous, active-high reset.
  spectral_vector  in  384  16 bands x 24-bit; band i at bits [i*24 +: 24].
  in_valid  in  1  one-cycle frame strobe; no backpressure to the source.
  m_data  out  24  current band word.
  m_band  out  4  band index of m_data, 0..15.
  m_valid  out  1  output beat valid.
  m_ready  in  1  downstream accept.
  m_first  out  1  high on the band-0 beat.
  m_last  out  1  high on the final beat of a frame.
  m_sum  out  1  high on the checksum beat.
  overrun_count  out  16  number of dropped frames, saturating.
  frame_count  out  16  number of completed frames, wrapping.
REQ-002 SHALL have no parameters; widths are fixed as listed.

Function
REQ-003 A beat SHALL transfer on a rising edge where m_valid=1 and m_ready=1.
REQ-004 While m_valid=1 and m_ready=0, m_data, m_band, m_first, m_last and m_sum SHALL be held stable.
REQ-005 The block SHALL hold two 384-bit frame registers: active (currently being sent) and pending (one-deep queue), plus a pending_full flag.
REQ-006 The state machine SHALL have states IDLE and SEND, plus SUM when the configuration macro of REQ-020 is defined.
REQ-007 In IDLE, in_valid SHALL load active and move to SEND; m_valid SHALL rise on the next cycle with band 0. Latency is 1 cycle.
REQ-008 In SEND, m_data SHALL equal active band[m_band], and the band index SHALL advance by 1 on each transfer.
REQ-009 In SEND with in_valid, pending empty and no frame-end transfer, the frame SHALL load pending and set pending_full.
REQ-010 In SEND with in_valid and pending full, the new frame SHALL be dropped and overrun_count SHALL increment, saturating at 16'hFFFF.
REQ-011 On the frame-end transfer, frame_count SHALL increment (wrapping). Then:
  - if pending is full: pending SHALL move to active, the band index SHALL reset to 0, and m_valid SHALL stay high with no bubble;
  - otherwise: go to IDLE and drop m_valid.
REQ-012 Frame-end transfer coinciding with in_valid:
  - pending full: pending moves to active and the new frame loads pending; nothing is dropped.
  - pending empty: the new frame loads active directly; stay in SEND at band 0.
REQ-013 m_first SHALL equal (m_valid and band index = 0).
REQ-014 m_sum SHALL be 0 in SEND.
REQ-015 When in_valid is 0, spectral_vector SHALL be ignored.

Reset
REQ-016 While rst=1, on the clock edge the block SHALL clear:
  - state to IDLE;
  - m_valid, m_first, m_last and m_sum to 0;
  - m_band and m_data to 0;
  - pending_full to 0;
  - overrun_count and frame_count to 0.
REQ-017 Assertion of rst mid-frame SHALL abandon both active and pending frames with no partial completion; frame_count is not incremented.
REQ-018 in_valid coincident with rst=1 SHALL be ignored.
REQ-019 Frame buffer contents after reset are don't-care.

Configuration
REQ-020 The macro BOREAL_SERIALIZER_CHECKSUM_EN SHALL select the frame format.
  - Defined: after the band-15 transfer, the state SHALL move to SUM and emit one extra beat with m_data = (sum of the 16 bands) mod 2^24, m_sum=1, m_band=0, m_first=0, m_last=1. The band-15 beat then has m_last=0. The frame-end transfer is the SUM-beat transfer. Frames are 17 beats.
  - Undefined: the band-15 beat SHALL carry m_last=1, m_sum SHALL be tied to 0, the SUM state SHALL not exist, and frames are 16 beats.
REQ-021 The checksum SHALL be computed from the active frame and SHALL be unaffected by writes to pending.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
  - Single frame: band i = i+1, m_ready=1 continuous. Required: first m_valid in the cycle after in_valid; beats 1..16 in order; m_first on band 0; m_last on band 15. With the macro defined, a 17th beat with m_data=136 and m_sum=1. frame_count=1.
  - Backpressure: m_ready toggling 1,0,0,1 during the frame. Required: outputs stable while stalled; no band skipped or repeated.
  - Back-to-back: second in_valid at band 5 of frame A, m_ready=1. Required: frame B band 0 immediately follows A's last beat with no bubble; overrun_count=0.
  - Overrun: three in_valid strobes during frame A with m_ready=0. Required: second frame queued, third dropped, overrun_count=1. Also preload overrun_count to 16'hFFFE, force 3 further drops, and require it to saturate at 16'hFFFF.
  - Coincidence: in_valid on the same cycle as A's frame-end transfer with pending empty. Required: next beat is new-frame band 0; no drop.
  - Reset mid-frame: rst at band 7 with pending full. Required: next cycle m_valid=0, both counters 0; the next in_valid restarts at band 0.

Source files
------------

// File: rtl/boreal_spectral_serializer.sv
// boreal_spectral_serializer
// Takes a 16-band x 24-bit spectral frame in one strobe and streams it out one
// band per beat over a valid/ready interface.
// A one-deep pending register absorbs a frame that arrives mid-stream.
// Frames that arrive while pending is already full are dropped and counted.
// Optional feature macro: BOREAL_SERIALIZER_CHECKSUM_EN
//   defined   -> each frame gets a 17th beat carrying the 24-bit band sum (m_sum=1)
//   undefined -> 16-beat frames, m_last on band 15, m_sum tied low
module boreal_spectral_serializer (
  input  logic         clk,
  input  logic         rst,
  input  logic [383:0] spectral_vector,
  input  logic         in_valid,
  output logic [23:0]  m_data,
  output logic [3:0]   m_band,
  output logic         m_valid,
  input  logic         m_ready,
  output logic         m_first,
  output logic         m_last,
  output logic         m_sum,
  output logic [15:0]  overrun_count,
  output logic [15:0]  frame_count
);

`ifdef BOREAL_SERIALIZER_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, SUM = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1} state_t;
`endif

  state_t         state_q, state_d;
  logic [383:0]   active_q, active_d;
  logic [383:0]   pending_q, pending_d;
  logic           pending_full_q, pending_full_d;
  logic [3:0]     band_q, band_d;
  logic [15:0]    overrun_q, overrun_d;
  logic [15:0]    frame_q, frame_d;

  logic [23:0]    active_band [16];
  logic           xfer;
  logic           frame_end;

  // Split the active frame into band words for indexed selection.
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_band
      assign active_band[gi] = active_q[gi*24 +: 24];
    end
  endgenerate

`ifdef BOREAL_SERIALIZER_CHECKSUM_EN
  logic [23:0] checksum;

  // Checksum is taken only from the active frame, so pending writes never disturb it.
  always_comb begin
    checksum = 24'd0;
    for (int i = 0; i < 16; i++) begin
      checksum = checksum + active_band[i];
    end
  end
`endif

  // Output decode: everything is derived from registered state, nothing from inputs.
  always_comb begin
    m_valid = (state_q != IDLE);
    m_band  = 4'd0;
    m_data  = 24'd0;
    m_first = 1'b0;
    m_last  = 1'b0;
    m_sum   = 1'b0;
    if (state_q == SEND) begin
      m_band  = band_q;
      m_data  = active_band[band_q];
      m_first = (band_q == 4'd0);
`ifndef BOREAL_SERIALIZER_CHECKSUM_EN
      m_last  = (band_q == 4'd15);
`endif
    end
`ifdef BOREAL_SERIALIZER_CHECKSUM_EN
    if (state_q == SUM) begin
      m_data = checksum;
      m_last = 1'b1;
      m_sum  = 1'b1;
    end
`endif
  end

  assign overrun_count = overrun_q;
  assign frame_count   = frame_q;

  // Transfer and frame-end detection; the frame ends on the final beat's handshake.
  always_comb begin
    xfer = (state_q != IDLE) && m_ready;
`ifdef BOREAL_SERIALIZER_CHECKSUM_EN
    frame_end = xfer && (state_q == SUM);
`else
    frame_end = xfer && (state_q == SEND) && (band_q == 4'd15);
`endif
  end

  // Next-state logic: sequencing, pending queue management and counters.
  always_comb begin
    state_d        = state_q;
    active_d       = active_q;
    pending_d      = pending_q;
    pending_full_d = pending_full_q;
    band_d         = band_q;
    overrun_d      = overrun_q;
    frame_d        = frame_q;

    if (frame_end) begin
      frame_d = frame_q + 16'd1;
      band_d  = 4'd0;
      if (pending_full_q) begin
        // Promote pending with no bubble; a coincident frame refills pending.
        active_d = pending_q;
        state_d  = SEND;
        if (in_valid) begin
          pending_d = spectral_vector;
        end else begin
          pending_full_d = 1'b0;
        end
      end else if (in_valid) begin
        // Pending empty: the coincident frame goes straight to active.
        active_d = spectral_vector;
        state_d  = SEND;
      end else begin
        state_d = IDLE;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            active_d = spectral_vector;
            band_d   = 4'd0;
            state_d  = SEND;
          end
        end
        SEND: begin
          if (xfer) begin
`ifdef BOREAL_SERIALIZER_CHECKSUM_EN
            if (band_q == 4'd15) begin
              state_d = SUM;
              band_d  = 4'd0;
            end else begin
              band_d = band_q + 4'd1;
            end
`else
            band_d = band_q + 4'd1;
`endif
          end
        end
`ifdef BOREAL_SERIALIZER_CHECKSUM_EN
        SUM: begin
          // Leaving SUM only happens through the frame-end path above.
        end
`endif
        default: begin
          state_d = IDLE;
        end
      endcase

      // Mid-stream arrivals: queue one, drop the rest.
      if ((state_q != IDLE) && in_valid) begin
        if (!pending_full_q) begin
          pending_d      = spectral_vector;
          pending_full_d = 1'b1;
        end else if (overrun_q != 16'hFFFF) begin
          overrun_d = overrun_q + 16'd1;
        end
      end
    end
  end

  // State register; frame buffers are left unreset since their contents are don't-care.
  always_ff @(posedge clk) begin
    active_q  <= active_d;
    pending_q <= pending_d;
    if (rst) begin
      state_q        <= IDLE;
      pending_full_q <= 1'b0;
      band_q         <= 4'd0;
      overrun_q      <= 16'd0;
      frame_q        <= 16'd0;
    end else begin
      state_q        <= state_d;
      pending_full_q <= pending_full_d;
      band_q         <= band_d;
      overrun_q      <= overrun_d;
      frame_q        <= frame_d;
    end
  end

endmodule

// File: tb/tb_boreal_spectral_serializer.sv
// Testbench for boreal_spectral_serializer.
// Honours BOREAL_SERIALIZER_CHECKSUM_EN to pick the expected frame length.
module tb_boreal_spectral_serializer;

`ifdef BOREAL_SERIALIZER_CHECKSUM_EN
  localparam int BEATS = 17;
`else
  localparam int BEATS = 16;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [383:0] spectral_vector = '0;
  logic         in_valid = 1'b0;
  logic         m_ready = 1'b0;
  logic [23:0]  m_data;
  logic [3:0]   m_band;
  logic         m_valid;
  logic         m_first;
  logic         m_last;
  logic         m_sum;
  logic [15:0]  overrun_count;
  logic [15:0]  frame_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a FIFO of accepted frames (head = frame on the wire),
  // the beat position within the head frame, and the two counters.
  logic [383:0] fq[$];
  int mpos = 0;
  int mfrm = 0;
  int movr = 0;

  boreal_spectral_serializer dut (
    .clk(clk), .rst(rst), .spectral_vector(spectral_vector), .in_valid(in_valid),
    .m_data(m_data), .m_band(m_band), .m_valid(m_valid), .m_ready(m_ready),
    .m_first(m_first), .m_last(m_last), .m_sum(m_sum),
    .overrun_count(overrun_count), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic        rdy;
    logic        ev;
    logic [23:0] ed;
    logic [3:0]  eb;
    logic        ef;
    logic        el;
    logic        es;
    logic [15:0] efc;
  } vec_t;

  vec_t tbl [0:63];
  int   ntbl = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] word(input logic [383:0] v, input int i);
    return v[i*24 +: 24];
  endfunction

  function automatic logic [23:0] csum(input logic [383:0] v);
    logic [23:0] s = 24'd0;
    for (int i = 0; i < 16; i++) s = s + v[i*24 +: 24];
    return s;
  endfunction

  function automatic logic [383:0] randvec();
    logic [383:0] v;
    for (int k = 0; k < 12; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [383:0] incvec();
    logic [383:0] v;
    for (int i = 0; i < 16; i++) v[i*24 +: 24] = 24'(i + 1);
    return v;
  endfunction

  // One clock cycle: drive inputs, clock, advance the model, optionally compare.
  task automatic cyc(input logic iv, input logic rdy, input logic r,
                     input logic [383:0] vec, input bit cmp);
    bit          xfer;
    logic        ev;
    logic [23:0] ed;
    logic [3:0]  eb;
    rst = r; in_valid = iv; m_ready = rdy; spectral_vector = vec;
    @(posedge clk);
    #1;
    if (r) begin
      fq.delete(); mpos = 0; mfrm = 0; movr = 0;
    end else begin
      xfer = (fq.size() > 0) && rdy;
      if (xfer) begin
        if (mpos == BEATS - 1) begin
          void'(fq.pop_front());
          mpos = 0;
          mfrm = (mfrm + 1) % 65536;
        end else begin
          mpos++;
        end
      end
      if (iv) begin
        if (fq.size() < 2) fq.push_back(vec);
        else if (movr < 65535) movr++;
      end
    end
    in_valid = 1'b0;
    if (cmp) begin
      ev = (fq.size() > 0);
      chk("model_valid", m_valid, ev);
      chk("model_frame_count", frame_count, mfrm[15:0]);
      chk("model_overrun_count", overrun_count, movr[15:0]);
      if (ev) begin
        ed = (mpos < 16) ? word(fq[0], mpos) : csum(fq[0]);
        eb = (mpos < 16) ? 4'(mpos) : 4'd0;
        chk("model_data", m_data, ed);
        chk("model_band", m_band, eb);
        chk("model_first", m_first, mpos == 0);
        chk("model_last", m_last, mpos == BEATS - 1);
        chk("model_sum", m_sum, mpos == 16);
      end else begin
        chk("model_first_idle", m_first, 1'b0);
      end
    end
  endtask

  // Build table rows for one incrementing-data frame; bp selects the 1,0,0,1 ready pattern.
  task automatic add_frame(input bit bp, input logic [15:0] fc_before);
    logic [3:0] pat = 4'b1001;
    int p = 0;
    int r = 0;
    logic rdy;
    while (1) begin
      rdy = bp ? pat[r % 4] : 1'b1;
      if (r > 0 && rdy) p++;
      tbl[ntbl].iv  = (r == 0);
      tbl[ntbl].rdy = rdy;
      tbl[ntbl].ev  = (p < BEATS);
      tbl[ntbl].ed  = (p < 16) ? 24'(p + 1) : 24'd136;
      tbl[ntbl].eb  = (p < 16) ? 4'(p) : 4'd0;
      tbl[ntbl].ef  = (p == 0);
      tbl[ntbl].el  = (p == BEATS - 1);
      tbl[ntbl].es  = (p == 16);
      tbl[ntbl].efc = (p < BEATS) ? fc_before : fc_before + 16'd1;
      ntbl++;
      r++;
      if (p >= BEATS) break;
    end
  endtask

  initial begin
    logic [383:0] va, vb, vc, vd, fr;

    add_frame(1'b0, 16'd0);
    add_frame(1'b1, 16'd1);

    // Reset state
    cyc(1'b0, 1'b0, 1'b1, '0, 1'b1);
    cyc(1'b1, 1'b1, 1'b1, randvec(), 1'b1);
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_m_data", m_data, 24'd0);
    chk("rst_m_band", m_band, 4'd0);
    chk("rst_m_first", m_first, 1'b0);
    chk("rst_m_last", m_last, 1'b0);
    chk("rst_m_sum", m_sum, 1'b0);
    chk("rst_overrun", overrun_count, 16'd0);
    chk("rst_frames", frame_count, 16'd0);

    // Table: single frame with continuous ready, then a backpressured frame
    fr = incvec();
    for (int i = 0; i < ntbl; i++) begin
      cyc(tbl[i].iv, tbl[i].rdy, 1'b0, fr, 1'b1);
      chk("tbl_valid", m_valid, tbl[i].ev);
      chk("tbl_frame_count", frame_count, tbl[i].efc);
      if (tbl[i].ev) begin
        chk("tbl_data", m_data, tbl[i].ed);
        chk("tbl_band", m_band, tbl[i].eb);
        chk("tbl_first", m_first, tbl[i].ef);
        chk("tbl_last", m_last, tbl[i].el);
        chk("tbl_sum", m_sum, tbl[i].es);
      end
    end

    // Back-to-back: frame B strobed while A shows band 5
    va = randvec(); vb = randvec();
    cyc(1'b0, 1'b1, 1'b1, '0, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, va, 1'b1);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b0, '0, 1'b1);
    chk("b2b_band5", m_band, 4'd5);
    cyc(1'b1, 1'b1, 1'b0, vb, 1'b1);
    for (int i = 0; i < BEATS - 7; i++) cyc(1'b0, 1'b1, 1'b0, '0, 1'b1);
    chk("b2b_a_last", m_last, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, '0, 1'b1);
    chk("b2b_no_bubble", m_valid, 1'b1);
    chk("b2b_b_band0", m_band, 4'd0);
    chk("b2b_b_data0", m_data, word(vb, 0));
    chk("b2b_overrun", overrun_count, 16'd0);
    chk("b2b_frames", frame_count, 16'd1);

    // Coincidence: new frame strobed on A's frame-end transfer, pending empty
    va = randvec(); vc = randvec();
    cyc(1'b0, 1'b1, 1'b1, '0, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, va, 1'b1);
    for (int i = 0; i < BEATS - 1; i++) cyc(1'b0, 1'b1, 1'b0, '0, 1'b1);
    chk("coin_a_last", m_last, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, vc, 1'b1);
    chk("coin_valid", m_valid, 1'b1);
    chk("coin_band0", m_band, 4'd0);
    chk("coin_data0", m_data, word(vc, 0));
    chk("coin_overrun", overrun_count, 16'd0);
    chk("coin_frames", frame_count, 16'd1);

    // Reset mid-frame with pending full; rst coincides with in_valid
    va = randvec(); vb = randvec(); vc = randvec(); vd = randvec();
    cyc(1'b0, 1'b1, 1'b1, '0, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, va, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, vb, 1'b1);
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 1'b0, '0, 1'b1);
    chk("mid_band7", m_band, 4'd7);
    cyc(1'b1, 1'b1, 1'b1, vc, 1'b1);
    chk("mid_rst_valid", m_valid, 1'b0);
    chk("mid_rst_frames", frame_count, 16'd0);
    chk("mid_rst_overrun", overrun_count, 16'd0);
    cyc(1'b0, 1'b1, 1'b0, '0, 1'b1);
    chk("mid_pending_gone", m_valid, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, vd, 1'b1);
    chk("mid_restart_band", m_band, 4'd0);
    chk("mid_restart_data", m_data, word(vd, 0));
    chk("mid_restart_first", m_first, 1'b1);

    // Overrun: three strobes with m_ready low, then drive the counter to saturation
    va = randvec(); vb = randvec(); vc = randvec();
    cyc(1'b0, 1'b0, 1'b1, '0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, va, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, vb, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, vc, 1'b1);
    chk("ovr_count1", overrun_count, 16'd1);
    chk("ovr_head_held", m_data, word(va, 0));
    for (int i = 0; i < 65533; i++) cyc(1'b1, 1'b0, 1'b0, vc, 1'b0);
    chk("ovr_fffe", overrun_count, 16'hFFFE);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, vc, 1'b1);
    chk("ovr_saturated", overrun_count, 16'hFFFF);
    // Drain: A then the queued B must come out intact
    for (int i = 0; i < 2 * BEATS + 2; i++) cyc(1'b0, 1'b1, 1'b0, '0, 1'b1);
    chk("ovr_drained_frames", frame_count, 16'd2);

    // Randomized traffic against the reference model
    cyc(1'b0, 1'b0, 1'b1, '0, 1'b1);
    for (int i = 0; i < 4000; i++) begin
      cyc($urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0,
          $urandom_range(0, 299) == 0, randvec(), 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
